// File: rtl/sram_vga_scanout_if.sv
// rtl/sram_vga_scanout_if.sv - upstream single-word write request channel into the scanout block
interface sram_vga_scanout_if;
  logic        wr_req;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/sram_vga_scanout.sv
// rtl/sram_vga_scanout.sv - 640x480 VGA scanout from async SRAM, blanking-time single-word writes
module sram_vga_scanout #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter logic [19:0] BASE_ADDR = 20'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_vga_scanout_if.slave    wr,
  output logic [19:0]          sram_addr,
  inout  wire  [15:0]          sram_dq,
  output logic                 ce_n,
  output logic                 ub_n,
  output logic                 lb_n,
  output logic                 oe_n,
  output logic                 we_n,
  output logic [4:0]           vga_r,
  output logic [5:0]           vga_g,
  output logic [4:0]           vga_b,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic                 frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Timing pipe bit order: {frame_start, de, hsync, vsync}; idle level has both syncs high.
  localparam logic [3:0] TIM_IDLE = 4'b0011;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [19:0]   pix_addr_q, pix_addr_d;
  logic [19:0]   sram_addr_q, sram_addr_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          wr_ack_q, wr_ack_d;
  logic [15:0]   dq_reg_q, dq_reg_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    tim1_q, tim1_d;
  logic [3:0]    tim2_q, tim2_d;
  logic [15:0]   rgb_q, rgb_d;

  logic          h_wrap, v_wrap;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic          active, active_nxt, window;
  logic [3:0]    tim_raw;

  always_comb begin
    h_wrap     = (h_cnt_q == H_LAST);
    v_wrap     = (v_cnt_q == V_LAST);
    h_nxt      = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_nxt      = !h_wrap ? v_cnt_q : (v_wrap ? '0 : v_cnt_q + 1'b1);
    active     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    active_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    // Both positions blank: the write's WR cycle sits on a blank position, and
    // a read issued during WR_HOLD only reaches the pins after the hold cycle.
    window     = (state_q == ST_IDLE) && wr.wr_req && !active && !active_nxt;

    tim_raw[3] = (h_cnt_q == '0) && (v_cnt_q == '0);
    tim_raw[2] = active;
    tim_raw[1] = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
    tim_raw[0] = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));

    h_cnt_d     = h_nxt;
    v_cnt_d     = v_nxt;
    pix_addr_d  = pix_addr_q;
    sram_addr_d = sram_addr_q;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    wr_ack_d    = 1'b0;
    dq_reg_d    = dq_reg_q;
    state_d     = state_q;
    tim1_d      = tim_raw;
    tim2_d      = tim1_q;
    rgb_d       = tim1_q[2] ? sram_dq : 16'h0000;

    if (active) begin
      sram_addr_d = pix_addr_q;
      oe_n_d      = 1'b0;
      pix_addr_d  = pix_addr_q + 20'd1;
    end
    if (h_wrap && v_wrap) begin
      pix_addr_d = BASE_ADDR;
    end

    case (state_q)
      ST_IDLE: begin
        if (window) begin
          state_d     = ST_WR;
          sram_addr_d = wr.wr_addr;
          dq_reg_d    = wr.wr_data;
          we_n_d      = 1'b0;
          wr_ack_d    = 1'b1;
        end
      end
      ST_WR:   state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      pix_addr_q  <= BASE_ADDR;
      sram_addr_q <= 20'd0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      wr_ack_q    <= 1'b0;
      dq_reg_q    <= 16'h0000;
      state_q     <= ST_IDLE;
      tim1_q      <= TIM_IDLE;
      tim2_q      <= TIM_IDLE;
      rgb_q       <= 16'h0000;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      pix_addr_q  <= pix_addr_d;
      sram_addr_q <= sram_addr_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      wr_ack_q    <= wr_ack_d;
      dq_reg_q    <= dq_reg_d;
      state_q     <= state_d;
      tim1_q      <= tim1_d;
      tim2_q      <= tim2_d;
      rgb_q       <= rgb_d;
    end
  end

  assign sram_dq   = ((state_q == ST_WR) || (state_q == ST_HOLD)) ? dq_reg_q : 16'hzzzz;
  assign sram_addr = sram_addr_q;
  assign oe_n      = oe_n_q;
  assign we_n      = we_n_q;
  assign ce_n      = 1'b0;
  assign ub_n      = 1'b0;
  assign lb_n      = 1'b0;
  assign wr.wr_ack = wr_ack_q;

  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign frame_start = tim2_q[3];
  assign de          = tim2_q[2];
  assign hsync       = tim2_q[1];
  assign vsync       = tim2_q[0];

endmodule

// File: tb/tb_sram_vga_scanout.sv
// tb/tb_sram_vga_scanout.sv - directed bench: timing, readout, blanking writes, frame wrap, reset mid-write
module tb_sram_vga_scanout;

  // Full horizontal timing; vertical shortened to 10 lines so whole frames fit the cycle budget.
  localparam int VA = 4;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_vga_scanout_if wr_if();

  wire  [15:0] sram_dq;
  logic [19:0] sram_addr;
  logic        ce_n, ub_n, lb_n, oe_n, we_n;
  logic [4:0]  vga_r;
  logic [5:0]  vga_g;
  logic [4:0]  vga_b;
  logic        hsync, vsync, de, frame_start;

  sram_vga_scanout #(
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .wr(wr_if.slave),
    .sram_addr(sram_addr), .sram_dq(sram_dq),
    .ce_n(ce_n), .ub_n(ub_n), .lb_n(lb_n), .oe_n(oe_n), .we_n(we_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
  );

  logic [15:0] mem [0:4095];
  logic        mem_init = 1'b0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  assign sram_dq = (!oe_n && we_n) ? mem[sram_addr[11:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'(i);
      mem_init <= 1'b1;
    end else if (!we_n) begin
      mem[sram_addr[11:0]] <= sram_dq;
    end
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  logic [15:0] rgb_out;
  logic        bus_free;
  assign rgb_out  = {vga_r, vga_g, vga_b};
  assign bus_free = (sram_dq === 16'hzzzz) || (sram_dq === 16'h0000);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic goto_cyc(input int c);
    int guard = 0;
    while (cyc != c && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) check_eq("goto_timeout", cyc, c);
  endtask

  task automatic raise_req(input logic [19:0] a, input logic [15:0] d);
    wr_if.wr_addr = a;
    wr_if.wr_data = d;
    wr_if.wr_req  = 1'b1;
  endtask

  initial begin
    int errs;
    int p, h, v;
    logic        exp_de;
    logic [15:0] exp_rgb;

    wr_if.wr_req  = 1'b0;
    wr_if.wr_addr = 20'd0;
    wr_if.wr_data = 16'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    check_eq("rst_oe_n", oe_n, 1);
    check_eq("rst_we_n", we_n, 1);
    check_eq("rst_wr_ack", wr_if.wr_ack, 0);
    check_eq("rst_hsync", hsync, 1);
    check_eq("rst_vsync", vsync, 1);
    check_eq("rst_de", de, 0);
    check_eq("rst_rgb", rgb_out, 0);
    check_eq("rst_fs", frame_start, 0);
    check_eq("rst_addr", sram_addr, 0);
    check_eq("rst_bus_free", bus_free, 1);
    check_eq("tie_ce_ub_lb", {ce_n, ub_n, lb_n}, 0);
    rst = 1'b0;

    goto_cyc(1);   check_eq("de_c1", de, 0);
    goto_cyc(2);   check_eq("de_c2", de, 1);
                   check_eq("fs_c2", frame_start, 1);
                   check_eq("rgb_px0", rgb_out, 16'h0000);
    goto_cyc(3);   check_eq("fs_c3", frame_start, 0);
                   check_eq("rgb_px1", rgb_out, 16'h0001);
    goto_cyc(102); check_eq("rgb_px100", rgb_out, 16'h0064);
    goto_cyc(641); check_eq("de_px639", de, 1);
                   check_eq("rgb_px639", rgb_out, 16'h027F);
    goto_cyc(642); check_eq("de_px640", de, 0);
                   check_eq("rgb_blank", rgb_out, 0);
    goto_cyc(657); check_eq("hs_657", hsync, 1);
    goto_cyc(658); check_eq("hs_658", hsync, 0);

    goto_cyc(700); check_eq("idle_addr", sram_addr, 20'h0027F);
                   check_eq("idle_oe_n", oe_n, 1);
    raise_req(20'h00123, 16'hA5A5);
    goto_cyc(701); check_eq("wr_we_n", we_n, 0);
                   check_eq("wr_ack", wr_if.wr_ack, 1);
                   check_eq("wr_oe_n", oe_n, 1);
                   check_eq("wr_addr", sram_addr, 20'h00123);
                   check_eq("wr_dq", sram_dq, 16'hA5A5);
    wr_if.wr_req = 1'b0;
    goto_cyc(702); check_eq("hold_we_n", we_n, 1);
                   check_eq("hold_ack", wr_if.wr_ack, 0);
                   check_eq("hold_addr", sram_addr, 20'h00123);
                   check_eq("hold_dq", sram_dq, 16'hA5A5);
    goto_cyc(703); check_eq("rel_bus_free", bus_free, 1);
                   check_eq("mem_123", mem[12'h123], 16'hA5A5);
    goto_cyc(753); check_eq("hs_753", hsync, 0);
    goto_cyc(754); check_eq("hs_754", hsync, 1);
    goto_cyc(1457); check_eq("hs_1457", hsync, 1);
    goto_cyc(1458); check_eq("hs_1458", hsync, 0);

    // Request raised mid-line 2; it must wait until counter (640,2) and leave video intact.
    goto_cyc(1700);
    raise_req(20'h00FFF, 16'h3C3C);
    errs = 0;
    while (we_n && cyc < 2400) begin
      p = cyc - 2;
      h = p % 800;
      v = p / 800;
      exp_de  = (h < 640) && (v < VA);
      exp_rgb = exp_de ? 16'(v * 640 + h) : 16'h0000;
      if (de !== exp_de || rgb_out !== exp_rgb || wr_if.wr_ack !== 1'b0) errs++;
      @(negedge clk);
    end
    check_eq("defer_start", cyc, 2241);
    check_eq("defer_video", errs, 0);
    check_eq("defer_ack", wr_if.wr_ack, 1);
    check_eq("defer_addr", sram_addr, 20'h00FFF);
    check_eq("defer_rgb", rgb_out, 16'(2 * 640 + 639));
    wr_if.wr_req = 1'b0;
    goto_cyc(2243); check_eq("mem_fff", mem[12'hFFF], 16'h3C3C);

    goto_cyc(3040); check_eq("last_addr", sram_addr, 20'h009FF);
    goto_cyc(3041); check_eq("last_rgb", rgb_out, 16'h09FF);
                    check_eq("last_de", de, 1);
    goto_cyc(3042); check_eq("after_last_de", de, 0);
    goto_cyc(4801); check_eq("vs_4801", vsync, 1);
    goto_cyc(4802); check_eq("vs_4802", vsync, 0);
    goto_cyc(6401); check_eq("vs_6401", vsync, 0);
    goto_cyc(6402); check_eq("vs_6402", vsync, 1);

    // Request at (799, last line) must not start: (0,0) follows.
    goto_cyc(7999);
    raise_req(20'h00124, 16'h1234);
    goto_cyc(8000); check_eq("wrap_we_n0", we_n, 1);
    goto_cyc(8001); check_eq("wrap_we_n1", we_n, 1);
                    check_eq("wrap_addr0", sram_addr, 20'h00000);
                    check_eq("wrap_oe_n", oe_n, 0);
    goto_cyc(8002); check_eq("wrap_fs", frame_start, 1);
                    check_eq("wrap_de", de, 1);
                    check_eq("wrap_rgb0", rgb_out, 16'h0000);
    goto_cyc(8293); check_eq("f2_px291", rgb_out, 16'hA5A5);
    goto_cyc(8294); check_eq("f2_px292", rgb_out, 16'h0124);
    goto_cyc(8640); check_eq("wrap_wait_we", we_n, 1);
                    check_eq("wrap_wait_ack", wr_if.wr_ack, 0);
    goto_cyc(8641); check_eq("wrap_wr_we", we_n, 0);
                    check_eq("wrap_wr_ack", wr_if.wr_ack, 1);
                    check_eq("wrap_wr_addr", sram_addr, 20'h00124);
    wr_if.wr_req = 1'b0;
    goto_cyc(8643); check_eq("mem_124", mem[12'h124], 16'h1234);

    goto_cyc(8700);
    raise_req(20'h00200, 16'hBEEF);
    goto_cyc(8701); check_eq("mid_we_n", we_n, 0);
    rst = 1'b1;
    wr_if.wr_req = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_we_n", we_n, 1);
    check_eq("mid_rst_ack", wr_if.wr_ack, 0);
    check_eq("mid_rst_bus", bus_free, 1);
    check_eq("mid_rst_oe_n", oe_n, 1);
    check_eq("mid_rst_addr", sram_addr, 0);
    rst = 1'b0;
    goto_cyc(2);   check_eq("mid_fs", frame_start, 1);
                   check_eq("mid_de", de, 1);
                   check_eq("mid_rgb", rgb_out, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
